// File: rtl/ep01_pkg.sv
// Shared definitions for the EP1 exercise set: index width, the default
// part-C truth table and the 4-bit index type.
package ep01_pkg;

  localparam int unsigned IDX_W = 4;

  // Bit i is f for index i = {a,b,c,d}; set for the primes 2,3,5,7,11,13.
  localparam logic [15:0] EP01C_TT_DEFAULT = 16'h28AC;

  typedef logic [IDX_W-1:0] ep01_idx_t;

endpackage : ep01_pkg

// File: rtl/ep01_c_lut.sv
// Combinational 16-entry minterm lookup.
// Ports:
//   a, b, c, d : function inputs, a is the MSB of the index
//   f          : TRUTH_TABLE[{a,b,c,d}], zero latency
module ep01_c_lut
  import ep01_pkg::*;
#(
  parameter logic [15:0] TRUTH_TABLE = EP01C_TT_DEFAULT
) (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic f
);

  ep01_idx_t idx;

  assign idx = {a, b, c, d};
  assign f   = TRUTH_TABLE[idx];

endmodule : ep01_c_lut

// File: rtl/ep01_c.sv
// EP1 part C leaf cell: fixed four-input Boolean function with a
// registered, enable-gated copy for downstream synchronous logic.
// Ports:
//   clk   : system clock, rising edge active
//   rst_n : asynchronous active-low reset (clears f_q only)
//   a..d  : function inputs, a = MSB of index
//   en    : capture enable for f_q
//   f     : combinational function output, valid during reset
//   f_q   : registered function output, one-cycle latency
module ep01_c
  import ep01_pkg::*;
#(
  parameter logic [15:0] TRUTH_TABLE = EP01C_TT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  input  logic en,
  output logic f,
  output logic f_q
);

  // Function lookup
  ep01_c_lut #(
    .TRUTH_TABLE (TRUTH_TABLE)
  ) u_lut (
    .a (a),
    .b (b),
    .c (c),
    .d (d),
    .f (f)
  );

  // Registered copy; holds while en is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q <= 1'b0;
    end else if (en) begin
      f_q <= f;
    end
  end

endmodule : ep01_c

// File: tb/tb_ep01_c.sv
// Self-checking bench for ep01_c: table-driven exhaustive sweep of the
// default and an overridden truth table, plus registered-path sequences
// checked through an expected-value queue.
module tb_ep01_c;

  logic clk;
  logic rst_n;
  logic a, b, c, d;
  logic en;
  logic f, f_q;
  logic f2, f_q2;

  int tests  = 0;
  int failed = 0;

  logic exp_q[$];
  logic model_fq;

  typedef struct {
    logic [3:0] idx;
    logic       exp_f;   // default table
    logic       exp_f2;  // 16'h8001 override
  } vec_t;

  vec_t vecs[16];

  ep01_c u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .en    (en),
    .f     (f),
    .f_q   (f_q)
  );

  ep01_c #(
    .TRUTH_TABLE (16'h8001)
  ) u_dut_ovr (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .en    (en),
    .f     (f2),
    .f_q   (f_q2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "timeout");
  end

  function automatic logic is_prime(input logic [3:0] v);
    case (v)
      4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13: is_prime = 1'b1;
      default:                              is_prime = 1'b0;
    endcase
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic set_idx(input logic [3:0] v);
    {a, b, c, d} = v;
  endtask

  // Drive one cycle of stimulus; expected f_q goes into the queue and is
  // popped once the capturing edge has passed.
  task automatic step(input logic [3:0] v, input logic e, input string name);
    logic exp;
    @(negedge clk);
    set_idx(v);
    en = e;
    if (e) model_fq = is_prime(v);
    exp_q.push_back(model_fq);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({name, "_queue_empty"}, 1'b1, 1'b0);
    end else begin
      exp = exp_q.pop_front();
      check(name, f_q, exp);
    end
  endtask

  initial begin
    // Expected values written out by hand from the specification table.
    vecs[0]  = '{4'b0000, 1'b0, 1'b1};
    vecs[1]  = '{4'b0001, 1'b0, 1'b0};
    vecs[2]  = '{4'b0010, 1'b1, 1'b0};
    vecs[3]  = '{4'b0011, 1'b1, 1'b0};
    vecs[4]  = '{4'b0100, 1'b0, 1'b0};
    vecs[5]  = '{4'b0101, 1'b1, 1'b0};
    vecs[6]  = '{4'b0110, 1'b0, 1'b0};
    vecs[7]  = '{4'b0111, 1'b1, 1'b0};
    vecs[8]  = '{4'b1000, 1'b0, 1'b0};
    vecs[9]  = '{4'b1001, 1'b0, 1'b0};
    vecs[10] = '{4'b1010, 1'b0, 1'b0};
    vecs[11] = '{4'b1011, 1'b1, 1'b0};
    vecs[12] = '{4'b1100, 1'b0, 1'b0};
    vecs[13] = '{4'b1101, 1'b1, 1'b0};
    vecs[14] = '{4'b1110, 1'b0, 1'b0};
    vecs[15] = '{4'b1111, 1'b0, 1'b1};

    rst_n    = 1'b0;
    en       = 1'b0;
    model_fq = 1'b0;
    set_idx(4'b0000);
    #1;
    check("reset_f_q", f_q, 1'b0);
    check("reset_f_q_ovr", f_q2, 1'b0);

    // Exhaustive sweep while held in reset: f must be valid regardless.
    for (int i = 0; i < 16; i++) begin
      set_idx(vecs[i].idx);
      #10;
      check($sformatf("sweep_f_%04b", vecs[i].idx), f, vecs[i].exp_f);
      check($sformatf("sweep_ovr_f_%04b", vecs[i].idx), f2, vecs[i].exp_f2);
      check($sformatf("sweep_f_q_in_reset_%04b", vecs[i].idx), f_q, 1'b0);
    end

    // Reset release: no capture until the first rising edge afterwards.
    @(negedge clk);
    set_idx(4'b0111);
    en    = 1'b1;
    rst_n = 1'b1;
    #1;
    check("release_before_edge", f_q, 1'b0);
    @(posedge clk);
    #1;
    check("release_first_edge", f_q, 1'b1);
    model_fq = 1'b1;

    // Registered path
    step(4'b0011, 1'b1, "reg_0011");
    step(4'b1000, 1'b1, "reg_1000");
    step(4'b1101, 1'b1, "reg_1101");
    step(4'b0110, 1'b1, "reg_0110");
    step(4'b0011, 1'b1, "reg_0011_again");

    // Enable hold: f_q keeps 1 while f is 0
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 1'b0, $sformatf("hold_%0d", i));
      check($sformatf("hold_f_%0d", i), f, 1'b0);
    end

    // Async reset mid-cycle
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_f_q", f_q, 1'b0);
    set_idx(4'b0101);
    #1;
    check("async_reset_f", f, 1'b1);
    check("async_reset_f_ovr", f2, 1'b0);
    @(posedge clk);
    #1;
    check("async_reset_held_f_q", f_q, 1'b0);
    model_fq = 1'b0;

    // Release again, then capture a zero after a one via the queue
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1011, 1'b1, "post_reset_1011");
    step(4'b1111, 1'b1, "post_reset_1111");
    check("post_reset_f_q_ovr", f_q2, 1'b1);

    if (exp_q.size() != 0) check("queue_drained", 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_ep01_c
